pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter WDT_LIMIT, default 1024, consecutive-stall cycle count that raises stall_timeout (legal 2..65535).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 stallreq_if  input  1  fetch stage stall request.
REQ-005 stallreq_id  input  1  decode stage stall request (load-use hazard).
REQ-006 stallreq_ex  input  1  execute stage stall request (multi-cycle op).
REQ-007 stallreq_mem  input  1  memory stage stall request.
REQ-008 flush_req  input  1  exception/redirect request, single-cycle pulse.
REQ-009 flush_pc  input  32  redirect target, valid with flush_req.
REQ-010 stall  output  6  per-stage hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = hold.
REQ-011 flush  output  1  clear all pipeline registers this cycle.
REQ-012 new_pc  output  32  PC to load while flush=1.
REQ-013 stall_timeout  output  1  sticky watchdog flag.
REQ-014 stall_cycles  output  32  performance count of cycles with stall[0]=1.
REQ-015 flush_count  output  16  performance count of flushes issued.

Function
REQ-016 States: RUN, FLUSH; FLUSH lasts exactly one cycle then returns to RUN.
REQ-017 stall SHALL be combinational from requests and state, zero-cycle latency.
REQ-018 In RUN, highest-priority request selects stall: mem 6'b011111, ex 6'b001111, id 6'b000111, if 6'b000011, none 6'b000000.
REQ-019 stall bit k set SHALL imply bits 0..k-1 set; pattern 6'b111111 never produced.
REQ-020 flush_req sampled high in RUN SHALL capture flush_pc and enter FLUSH next cycle (1-cycle latency).
REQ-021 In FLUSH: flush=1, new_pc=captured flush_pc, stall=6'b000000 regardless of requests.
REQ-022 In RUN: flush=0, new_pc=0.
REQ-023 flush_req while in FLUSH SHALL be ignored (no capture, no second flush).
REQ-024 flush_req and any stallreq in the same RUN cycle: stall pattern applies that cycle, flush follows next cycle.
REQ-025 Watchdog counter increments each cycle stall!=0, clears when stall==0, saturates at WDT_LIMIT.
REQ-026 stall_timeout SHALL set the cycle after counter reaches WDT_LIMIT and remain 1 until reset; it does not alter stall.

Reset
REQ-027 rst=1 SHALL immediately force state RUN, flush=0, new_pc=0, captured pc=0, watchdog counter=0, stall_timeout=0, stall_cycles=0, flush_count=0.
REQ-028 While rst=1, stall SHALL be 6'b000000 regardless of requests.
REQ-029 rst asserted during FLUSH SHALL abort the flush; no flush pulse after release.

Configuration
REQ-030 Macro PIPE_CTRL_PERF_EN defined: stall_cycles and flush_count increment as specified, each saturating at all-ones.
REQ-031 Macro PIPE_CTRL_PERF_EN undefined: counters not built, stall_cycles and flush_count tied to 0; all other behaviour unchanged.

Verification
REQ-032 Reset: rst=1 with all stallreqs=1 -> stall=000000, flush=0, stall_timeout=0, counters 0.
REQ-033 Priority: stallreq_id=1 and stallreq_ex=1 same cycle -> stall=001111; drop ex -> stall=000111 same cycle.
REQ-034 Flush: flush_req=1, flush_pc=0x00000040, stallreq_mem=1 -> that cycle stall=011111; next cycle flush=1, new_pc=0x00000040, stall=000000; following cycle flush=0.
REQ-035 Back-to-back: flush_req high two consecutive cycles (0x40 then 0x80) -> exactly one flush pulse, new_pc=0x40, flush_count=1 (PERF_EN).
REQ-036 Watchdog, WDT_LIMIT=4: stallreq_ex held 3 cycles, released 1, held 5 -> stall_timeout=0 after first burst, 1 after 5th cycle of second burst, stays 1 after release.
REQ-037 Perf: PERF_EN defined, stallreq_if held 10 cycles -> stall_cycles=10; undefined -> stall_cycles=0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl: stall requests
// and redirects in, per-stage hold / flush / status out.
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    // Pipeline side: raises requests, consumes hold/flush controls.
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output flush_req, flush_pc,
        input  stall, flush, new_pc, stall_timeout, stall_cycles, flush_count
    );

    // Controller side.
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  flush_req, flush_pc,
        output stall, flush, new_pc, stall_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: priority stall encoding, one-cycle flush/redirect,
// stall watchdog. Define PIPE_CTRL_PERF_EN to build the stall/flush perf counters.
module pipe_ctrl #(
    parameter int unsigned WDT_LIMIT = 1024
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);
    localparam int unsigned WDT_W = 16;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned STG_W = 6;
    localparam int unsigned SC_W  = 32;
    localparam int unsigned FC_W  = 16;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [STG_W-1:0] stall_c;
    logic             flush_q;
    logic [PC_W-1:0]  pc_q;
    logic [WDT_W-1:0] wdt_cnt;
    logic             timeout_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and stall decode; the deepest requesting stage freezes itself
    // and everything upstream, while writeback is never held.
    always_comb begin
        state_nxt = state;
        stall_c   = '0;
        case (state)
            ST_RUN: begin
                if (bus.flush_req) begin
                    state_nxt = ST_FLUSH;
                end
                if (bus.stallreq_mem) begin
                    stall_c = 6'b011111;
                end else if (bus.stallreq_ex) begin
                    stall_c = 6'b001111;
                end else if (bus.stallreq_id) begin
                    stall_c = 6'b000111;
                end else if (bus.stallreq_if) begin
                    stall_c = 6'b000011;
                end
            end
            ST_FLUSH: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
        if (rst) begin
            stall_c = '0;
        end
    end

    // Flush pulse and redirect target, captured on entry to FLUSH only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q <= 1'b0;
            pc_q    <= '0;
        end else if (state_nxt == ST_FLUSH) begin
            flush_q <= 1'b1;
            pc_q    <= bus.flush_pc;
        end else begin
            flush_q <= 1'b0;
            pc_q    <= '0;
        end
    end

    // Watchdog: length of the current stall run, saturating; flag is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (stall_c == '0) begin
                wdt_cnt <= '0;
            end else if (wdt_cnt != WDT_W'(WDT_LIMIT)) begin
                wdt_cnt <= wdt_cnt + WDT_W'(1);
            end
            if (wdt_cnt == WDT_W'(WDT_LIMIT)) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [SC_W-1:0] stall_cycles_q;
    logic [FC_W-1:0] flush_count_q;

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall_c[0] && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + SC_W'(1);
            end
            if ((state == ST_FLUSH) && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + FC_W'(1);
            end
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_count  = '0;
`endif

    assign bus.stall         = stall_c;
    assign bus.flush         = flush_q;
    assign bus.new_pc        = pc_q;
    assign bus.stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_ctrl_if bus();

    pipe_ctrl #(.WDT_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        to;
        bit          cnt;
        logic [31:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] psc(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    function automatic logic [15:0] pfc(input int n);
        return PERF ? 16'(n) : 16'd0;
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, what, act, exp);
        end
    endtask

    // One cycle: drive inputs after the edge and queue what that cycle must show.
    task automatic step(input string tag, input bit r, input logic [3:0] req,
                        input bit fr, input logic [31:0] fpc,
                        input logic [5:0] es, input bit ef, input logic [31:0] epc,
                        input bit eto, input bit cnt,
                        input logic [31:0] esc, input logic [15:0] efc);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        bus.stallreq_mem = req[3];
        bus.stallreq_ex  = req[2];
        bus.stallreq_id  = req[1];
        bus.stallreq_if  = req[0];
        bus.flush_req    = fr;
        bus.flush_pc     = fpc;
        e.tag = tag; e.stall = es; e.flush = ef; e.pc = epc; e.to = eto;
        e.cnt = cnt; e.sc = esc; e.fc = efc;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk(e.tag, "stall",   32'(bus.stall),         32'(e.stall));
            chk(e.tag, "flush",   32'(bus.flush),         32'(e.flush));
            chk(e.tag, "new_pc",  bus.new_pc,             e.pc);
            chk(e.tag, "timeout", 32'(bus.stall_timeout), 32'(e.to));
            if (e.cnt) begin
                chk(e.tag, "stall_cycles", bus.stall_cycles,      e.sc);
                chk(e.tag, "flush_count",  32'(bus.flush_count),  32'(e.fc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus.stallreq_if  = 1'b0;
        bus.stallreq_id  = 1'b0;
        bus.stallreq_ex  = 1'b0;
        bus.stallreq_mem = 1'b0;
        bus.flush_req    = 1'b0;
        bus.flush_pc     = '0;

        // Reset with every request high.
        step("rst0", 1, 4'b1111, 0, 32'h0,  6'b000000, 0, 32'h0, 0, 1, 0, 0);
        step("rst1", 1, 4'b1111, 1, 32'h40, 6'b000000, 0, 32'h0, 0, 1, 0, 0);

        // Priority encoding, zero latency.
        step("prio_ex",  0, 4'b0110, 0, 0, 6'b001111, 0, 0, 0, 1, psc(0), 0);
        step("prio_id",  0, 4'b0010, 0, 0, 6'b000111, 0, 0, 0, 1, psc(1), 0);
        step("prio_if",  0, 4'b0001, 0, 0, 6'b000011, 0, 0, 0, 1, psc(2), 0);
        step("idle0",    0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0, 1, psc(3), 0);
        step("prio_mem", 0, 4'b1000, 0, 0, 6'b011111, 0, 0, 0, 1, psc(3), 0);
        step("prio_all", 0, 4'b1111, 0, 0, 6'b011111, 0, 0, 0, 1, psc(4), 0);
        step("idle1",    0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0, 1, psc(5), 0);

        // Flush together with a stall request.
        step("fl_req",  0, 4'b1000, 1, 32'h40, 6'b011111, 0, 32'h0,  0, 1, psc(5), 0);
        step("fl_act",  0, 4'b1000, 0, 32'h0,  6'b000000, 1, 32'h40, 0, 1, psc(6), 0);
        step("fl_done", 0, 4'b0000, 0, 32'h0,  6'b000000, 0, 32'h0,  0, 1, psc(6), pfc(1));

        // Back-to-back flush requests give a single pulse.
        step("rst2",  1, 4'b0000, 0, 32'h0,  6'b000000, 0, 32'h0,  0, 1, 0, 0);
        step("b2b_a", 0, 4'b0000, 1, 32'h40, 6'b000000, 0, 32'h0,  0, 1, 0, 0);
        step("b2b_b", 0, 4'b0000, 1, 32'h80, 6'b000000, 1, 32'h40, 0, 1, 0, 0);
        step("b2b_c", 0, 4'b0000, 0, 32'h0,  6'b000000, 0, 32'h0,  0, 1, 0, pfc(1));
        step("b2b_d", 0, 4'b0000, 0, 32'h0,  6'b000000, 0, 32'h0,  0, 1, 0, pfc(1));

        // Reset during FLUSH aborts it.
        step("ab_req",  0, 4'b0000, 1, 32'h100, 6'b000000, 0, 32'h0, 0, 1, 0, pfc(1));
        step("ab_rst",  1, 4'b0000, 0, 32'h0,   6'b000000, 0, 32'h0, 0, 1, 0, 0);
        step("ab_rel",  0, 4'b0000, 0, 32'h0,   6'b000000, 0, 32'h0, 0, 1, 0, 0);
        step("ab_idle", 0, 4'b0000, 0, 32'h0,   6'b000000, 0, 32'h0, 0, 1, 0, 0);

        // Watchdog with limit 4: 3-cycle burst, gap, 5-cycle burst.
        for (int i = 0; i < 3; i++)
            step($sformatf("wdt_a%0d", i), 0, 4'b0100, 0, 0, 6'b001111, 0, 0, 0, 0, 0, 0);
        step("wdt_gap", 0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0, 1, psc(3), 0);
        for (int i = 0; i < 5; i++)
            step($sformatf("wdt_b%0d", i), 0, 4'b0100, 0, 0, 6'b001111, 0, 0, 0, 0, 0, 0);
        step("wdt_rel",  0, 4'b0000, 0, 0, 6'b000000, 0, 0, 1, 1, psc(8), 0);
        step("wdt_hold", 0, 4'b0000, 0, 0, 6'b000000, 0, 0, 1, 0, 0, 0);

        // Perf: fetch stall for 10 cycles.
        step("rst3", 1, 4'b0001, 0, 0, 6'b000000, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 10; i++)
            step($sformatf("perf%0d", i), 0, 4'b0001, 0, 0, 6'b000011, 0, 0,
                 (i >= 6), (i == 1), 0, 0);
        step("perf_end", 0, 4'b0000, 0, 0, 6'b000000, 0, 0, 1, 1, psc(10), 0);

        begin
            int budget;
            budget = 10;
            while (q.size() != 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d expectations left, expected 0", q.size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
